// File: rtl/rst_ctrl_if.sv
// rst_ctrl_if -- signal bundle between the PLL/IO side, the reset controller
// and the machine it resets.
//   locked    : PLL lock flag (asynchronous to clk)
//   btn       : raw user reset button (asynchronous)
//   wdt_kick  : single-cycle watchdog restart strobe from the machine
//   sys_rst_n : registered active-low reset to the machine
//   rst_cause : cause of the last reset (00 power-on, 01 lock, 10 button, 11 wdt)
//   rst_count : saturating count of RUN->reset transitions
// Modport master is the reset controller; slave is the surrounding system.
interface rst_ctrl_if;
   logic       locked;
   logic       btn;
   logic       wdt_kick;
   logic       sys_rst_n;
   logic [1:0] rst_cause;
   logic [7:0] rst_count;

   modport master (
      input  locked, btn, wdt_kick,
      output sys_rst_n, rst_cause, rst_count
   );

   modport slave (
      output locked, btn, wdt_kick,
      input  sys_rst_n, rst_cause, rst_count
   );
endinterface

// File: rtl/rst_ctrl.sv
// rst_ctrl -- clock-domain reset controller.
// Holds the machine in reset until the PLL is locked, stretches reset for
// HOLD_CYCLES, debounces a user reset button, runs an optional kickable
// watchdog and records the cause and number of resets.
// Ports:
//   clk   : system clock (PLL output)
//   rst_n : asynchronous active-low power-on reset, clears all state
//   bus   : rst_ctrl_if.master (locked, btn, wdt_kick in;
//           sys_rst_n, rst_cause, rst_count out)
module rst_ctrl #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 48000,
   parameter int unsigned WDT_CYCLES      = 0,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   rst_ctrl_if.master  bus
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES     > 1) ? $clog2(HOLD_CYCLES)     : 1;
   localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned WDT_W  = (WDT_CYCLES      > 1) ? $clog2(WDT_CYCLES)      : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'((WDT_CYCLES == 0) ? 0 : WDT_CYCLES - 1);
   localparam bit                WDT_EN    = (WDT_CYCLES != 0);

   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;
   localparam logic [1:0] CAUSE_WDT  = 2'b11;

   typedef enum logic [1:0] {
      S_WAIT_LOCK,
      S_HOLD,
      S_RUN
   } state_t;

   // ---------------- synchronisers ----------------
   logic                   btn_norm;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic                   locked_s;
   logic                   btn_s;

   // Button normalised so that 1 always means pressed.
   assign btn_norm = BTN_ACTIVE_LOW ? ~bus.btn : bus.btn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_sync_q <= '0;
         btn_sync_q  <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
         btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_norm};
      end
   end

   assign locked_s = lock_sync_q[SYNC_STAGES-1];
   assign btn_s    = btn_sync_q[SYNC_STAGES-1];

   // ---------------- debounce ----------------
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;
   logic            btn_db_dly_q;
   logic            press;

   always_comb begin
      db_cnt_d = db_cnt_q + 1'b1;
      btn_db_d = btn_db_q;
      if (btn_s == btn_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         btn_db_d = btn_s;
         db_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q     <= '0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
      end else begin
         db_cnt_q     <= db_cnt_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_q;
      end
   end

   assign press = btn_db_q & ~btn_db_dly_q;

   // ---------------- FSM, watchdog, status ----------------
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
   logic              wdt_expire;
   logic [1:0]        cause_q, cause_d;
   logic [7:0]        count_q, count_d;
   logic              sys_rst_n_q;

   // Counter is parked at zero outside RUN (and when the watchdog is disabled)
   // so every RUN entry starts a fresh timeout.
   always_comb begin
      wdt_cnt_d = '0;
      if (WDT_EN && (state_q == S_RUN) && !bus.wdt_kick)
         wdt_cnt_d = wdt_cnt_q + 1'b1;
   end

   assign wdt_expire = WDT_EN && (wdt_cnt_q == WDT_LAST) && !bus.wdt_kick;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = '0;
      cause_d    = cause_q;
      count_d    = count_q;
      case (state_q)
         S_WAIT_LOCK: begin
            if (locked_s)
               state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!locked_s)
               state_d = S_WAIT_LOCK;
            else if (btn_db_q)
               hold_cnt_d = '0;
            else if (hold_cnt_q == HOLD_LAST)
               state_d = S_RUN;
            else
               hold_cnt_d = hold_cnt_q + 1'b1;
         end
         S_RUN: begin
            // One exit per cycle: lock loss beats button beats watchdog.
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cause_d = CAUSE_LOCK;
            end else if (press) begin
               state_d = S_HOLD;
               cause_d = CAUSE_BTN;
            end else if (wdt_expire) begin
               state_d = S_HOLD;
               cause_d = CAUSE_WDT;
            end
            if (state_d != S_RUN && count_q != 8'hFF)
               count_d = count_q + 8'd1;
         end
         default: state_d = S_WAIT_LOCK;
      endcase
   end

   // sys_rst_n is loaded from the next state so it is a clean flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT_LOCK;
         hold_cnt_q  <= '0;
         wdt_cnt_q   <= '0;
         cause_q     <= 2'b00;
         count_q     <= 8'd0;
         sys_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         wdt_cnt_q   <= wdt_cnt_d;
         cause_q     <= cause_d;
         count_q     <= count_d;
         sys_rst_n_q <= (state_d == S_RUN);
      end
   end

   assign bus.sys_rst_n = sys_rst_n_q;
   assign bus.rst_cause = cause_q;
   assign bus.rst_count = count_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl -- directed bench for rst_ctrl.
// DUT A: SYNC 2, HOLD 16, DEBOUNCE 8, WDT 100, active-low button.
// DUT B: SYNC 3, HOLD 1, DEBOUNCE 1, WDT disabled, active-high button.
module tb_rst_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   rst_ctrl_if bus_a ();
   rst_ctrl_if bus_b ();

   rst_ctrl #(
      .SYNC_STAGES     (2),
      .HOLD_CYCLES     (16),
      .DEBOUNCE_CYCLES (8),
      .WDT_CYCLES      (100),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.master)
   );

   rst_ctrl #(
      .SYNC_STAGES     (3),
      .HOLD_CYCLES     (1),
      .DEBOUNCE_CYCLES (1),
      .WDT_CYCLES      (0),
      .BTN_ACTIVE_LOW  (1'b0)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.master)
   );

   typedef struct {
      string       name;
      logic        locked;
      logic        btn;
      logic        kick;
      int unsigned ncyc;
      logic        exp_sys;
      logic [1:0]  exp_cause;
      logic [7:0]  exp_count;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string name, input logic lk, input logic bt, input logic kk,
                          input int unsigned n, input logic es, input logic [1:0] ec,
                          input logic [7:0] en);
      vec_t v;
      v.name = name; v.locked = lk; v.btn = bt; v.kick = kk; v.ncyc = n;
      v.exp_sys = es; v.exp_cause = ec; v.exp_count = en;
      vecs.push_back(v);
   endtask

   initial begin
      int unsigned resets;
      logic        bad;
      logic        prev;

      // Rows: inputs applied for ncyc edges, then outputs of DUT A compared.
      // Edge numbers in names are relative to the start of each scenario.
      add_vec("pwr_e18",    1'b1, 1'b1, 1'b1, 13, 1'b0, 2'd0, 8'd0);
      add_vec("pwr_e19",    1'b1, 1'b1, 1'b1,  1, 1'b1, 2'd0, 8'd0);
      add_vec("lloss_e2",   1'b0, 1'b1, 1'b1,  2, 1'b1, 2'd0, 8'd0);
      add_vec("lloss_e3",   1'b0, 1'b1, 1'b1,  1, 1'b0, 2'd1, 8'd1);
      add_vec("relock_e18", 1'b1, 1'b1, 1'b1, 18, 1'b0, 2'd1, 8'd1);
      add_vec("relock_e19", 1'b1, 1'b1, 1'b1,  1, 1'b1, 2'd1, 8'd1);
      add_vec("btn_e10",    1'b1, 1'b0, 1'b1, 10, 1'b1, 2'd1, 8'd1);
      add_vec("btn_e11",    1'b1, 1'b0, 1'b1,  1, 1'b0, 2'd2, 8'd2);
      add_vec("btn_e30",    1'b1, 1'b0, 1'b1, 19, 1'b0, 2'd2, 8'd2);
      add_vec("btnrel_e55", 1'b1, 1'b1, 1'b1, 25, 1'b0, 2'd2, 8'd2);
      add_vec("btnrel_e56", 1'b1, 1'b1, 1'b1,  1, 1'b1, 2'd2, 8'd2);
      add_vec("glitch_on",  1'b1, 1'b0, 1'b1,  5, 1'b1, 2'd2, 8'd2);
      add_vec("glitch_off", 1'b1, 1'b1, 1'b1, 30, 1'b1, 2'd2, 8'd2);

      bus_a.locked = 1'b1; bus_a.btn = 1'b1; bus_a.wdt_kick = 1'b1;
      bus_b.locked = 1'b1; bus_b.btn = 1'b0; bus_b.wdt_kick = 1'b0;

      // Asynchronous power-on reset.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_sys",   {31'd0, bus_a.sys_rst_n}, 0);
      check("rst_cause", {30'd0, bus_a.rst_cause}, 0);
      check("rst_count", {24'd0, bus_a.rst_count}, 0);
      repeat (3) step();
      check("rst_held_sys", {31'd0, bus_a.sys_rst_n}, 0);
      @(negedge clk) rst_n = 1'b1;

      // Power-up of DUT B: rises at edge 3+1+1.
      repeat (4) step();
      check("b_pwr_e4", {31'd0, bus_b.sys_rst_n}, 0);
      step();
      check("b_pwr_e5", {31'd0, bus_b.sys_rst_n}, 1);
      check("a_pwr_e5", {31'd0, bus_a.sys_rst_n}, 0);

      foreach (vecs[i]) begin
         bus_a.locked   = vecs[i].locked;
         bus_a.btn      = vecs[i].btn;
         bus_a.wdt_kick = vecs[i].kick;
         repeat (vecs[i].ncyc) step();
         check({vecs[i].name, ".sys"},   {31'd0, bus_a.sys_rst_n}, {31'd0, vecs[i].exp_sys});
         check({vecs[i].name, ".cause"}, {30'd0, bus_a.rst_cause}, {30'd0, vecs[i].exp_cause});
         check({vecs[i].name, ".count"}, {24'd0, bus_a.rst_count}, {24'd0, vecs[i].exp_count});
      end

      // DUT B: one-cycle press with DEBOUNCE 1 and HOLD 1.
      bus_b.btn = 1'b1;
      step();
      bus_b.btn = 1'b0;
      repeat (3) step();
      check("b_btn_e4", {31'd0, bus_b.sys_rst_n}, 1);
      step();
      check("b_btn_e5",       {31'd0, bus_b.sys_rst_n}, 0);
      check("b_btn_cause",    {30'd0, bus_b.rst_cause}, 2);
      step();
      check("b_btn_e6",       {31'd0, bus_b.sys_rst_n}, 1);
      check("b_btn_count",    {24'd0, bus_b.rst_count}, 1);

      // Watchdog: kick every 50 cycles for 1000 cycles.
      bad = 1'b0;
      for (int unsigned c = 1; c <= 1000; c++) begin
         bus_a.wdt_kick = (c % 50 == 0);
         step();
         if (!bus_a.sys_rst_n) bad = 1'b1;
      end
      check("wdt_kicked_1000", {31'd0, bad}, 0);
      bus_a.wdt_kick = 1'b0;
      repeat (99) step();
      check("wdt_e99",    {31'd0, bus_a.sys_rst_n}, 1);
      step();
      check("wdt_e100",   {31'd0, bus_a.sys_rst_n}, 0);
      check("wdt_cause",  {30'd0, bus_a.rst_cause}, 3);
      check("wdt_count",  {24'd0, bus_a.rst_count}, 3);

      // Back to RUN after HOLD, then a kick exactly on the expiry cycle.
      repeat (15) step();
      check("wdt_hold_e15", {31'd0, bus_a.sys_rst_n}, 0);
      step();
      check("wdt_hold_e16", {31'd0, bus_a.sys_rst_n}, 1);
      repeat (99) step();
      bus_a.wdt_kick = 1'b1;
      step();
      bus_a.wdt_kick = 1'b0;
      check("wdt_kick_on_expiry", {31'd0, bus_a.sys_rst_n}, 1);
      repeat (99) step();
      check("wdt2_e199",  {31'd0, bus_a.sys_rst_n}, 1);
      step();
      check("wdt2_e200",  {31'd0, bus_a.sys_rst_n}, 0);
      check("wdt2_count", {24'd0, bus_a.rst_count}, 4);

      // DUT B has never been kicked; its watchdog is disabled.
      check("b_wdt_off_sys",   {31'd0, bus_b.sys_rst_n}, 1);
      check("b_wdt_off_count", {24'd0, bus_b.rst_count}, 1);

      // Priority: lock loss and press event reach RUN in the same cycle.
      bus_a.wdt_kick = 1'b1;
      repeat (16) step();
      check("prio_run", {31'd0, bus_a.sys_rst_n}, 1);
      bus_a.btn = 1'b0;
      repeat (8) step();
      bus_a.locked = 1'b0;
      step();
      step();
      check("prio_e10",   {31'd0, bus_a.sys_rst_n}, 1);
      step();
      check("prio_e11",   {31'd0, bus_a.sys_rst_n}, 0);
      check("prio_cause", {30'd0, bus_a.rst_cause}, 1);
      check("prio_count", {24'd0, bus_a.rst_count}, 5);

      // Saturation: 300 watchdog resets on top of the 5 already counted.
      bus_a.locked = 1'b1; bus_a.btn = 1'b1; bus_a.wdt_kick = 1'b0;
      resets = 0;
      prev = bus_a.sys_rst_n;
      for (int unsigned e = 0; e < 40000; e++) begin
         step();
         if (prev && !bus_a.sys_rst_n) resets++;
         prev = bus_a.sys_rst_n;
         if (resets == 300) break;
      end
      check("sat_resets_seen", resets, 300);
      check("sat_count",       {24'd0, bus_a.rst_count}, 255);
      check("sat_cause",       {30'd0, bus_a.rst_cause}, 3);

      // Asynchronous reset in the middle of HOLD.
      repeat (5) step();
      check("midhold_sys", {31'd0, bus_a.sys_rst_n}, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_cause", {30'd0, bus_a.rst_cause}, 0);
      check("midrst_count", {24'd0, bus_a.rst_count}, 0);
      check("midrst_sys_b", {31'd0, bus_b.sys_rst_n}, 0);
      check("midrst_cnt_b", {24'd0, bus_b.rst_count}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
